// File: rtl/gbc_display_emitter.sv
`default_nettype none
// ============================================================================
// Module   : gbc_display_emitter
// Brief    : GBC LCD transmitter streaming a VRAM frame as DCLK/CLS/SPS/data.
//            Build option TEST_PATTERN_EN adds i_testPattern (vertical bars).
// Revision : 1.0 - initial release
// ============================================================================
module gbc_display_emitter #(
    parameter int CLK_DIV  = 4,
    parameter int H_PIXELS = 160,
    parameter int V_PIXELS = 144,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
`ifdef TEST_PATTERN_EN
    input  logic        i_testPattern,
`endif
    input  logic [7:0]  i_vramReadData,
    output logic [14:0] o_vramReadAddr,
    output logic        o_gbcDCLK,
    output logic        o_gbcCLS,
    output logic        o_gbcSPS,
    output logic [2:0]  o_gbcPixelData,
    output logic        o_busy,
    output logic        o_frameDone
);

    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_SYNC   = 3'd1;
    localparam logic [2:0]  c_ST_ACTIVE = 3'd2;
    localparam logic [2:0]  c_ST_HBLANK = 3'd3;
    localparam logic [2:0]  c_ST_VBLANK = 3'd4;

    localparam logic [7:0]  c_DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] c_H_LAST    = 16'(H_PIXELS - 1);
    localparam logic [15:0] c_HB_LAST   = 16'(H_BLANK - 1);
    localparam logic [15:0] c_LINE_LAST = 16'(H_PIXELS + H_BLANK - 1);
    localparam logic [15:0] c_V_LAST    = 16'(V_PIXELS - 1);
    localparam logic [15:0] c_VB_LAST   = 16'(V_BLANK - 1);
    localparam logic [14:0] c_ADDR_LAST = 15'(H_PIXELS * V_PIXELS - 1);

    logic [2:0]  r_state;
    logic [7:0]  r_div;
    logic        r_dclk;
    logic        r_cls;
    logic        r_sps;
    logic [2:0]  r_pix;
    logic        r_busy;
    logic        r_frame_done;
    logic [15:0] r_h;
    logic [15:0] r_v;
    logic [14:0] r_addr;

    logic        w_tick;
    logic        w_rise;
    logic        w_fall;
    logic [2:0]  w_nxt_state;
    logic [15:0] w_nxt_h;
    logic [15:0] w_nxt_v;
    logic [2:0]  w_pix;
    logic        w_unused_data;

    assign w_tick = (r_state != c_ST_IDLE) && (r_div == c_DIV_LAST);
    assign w_rise = w_tick && !r_dclk;
    assign w_fall = w_tick && r_dclk;

    // Only the bits carried to the panel are decoded.
    assign w_unused_data = ^{i_vramReadData[6:5], i_vramReadData[3:2], i_vramReadData[0]};

    // Next period's state/counters; applied on the DCLK rising-edge clock.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_h     = r_h;
        w_nxt_v     = r_v;
        case (r_state)
            c_ST_SYNC: begin
                w_nxt_state = c_ST_ACTIVE;
                w_nxt_h     = 16'd0;
                w_nxt_v     = 16'd0;
            end
            c_ST_ACTIVE: begin
                if (r_h == c_H_LAST) begin
                    w_nxt_state = c_ST_HBLANK;
                    w_nxt_h     = 16'd0;
                end else begin
                    w_nxt_h = r_h + 16'd1;
                end
            end
            c_ST_HBLANK: begin
                if (r_h == c_HB_LAST) begin
                    w_nxt_h = 16'd0;
                    if (r_v == c_V_LAST) begin
                        w_nxt_state = c_ST_VBLANK;
                        w_nxt_v     = 16'd0;
                    end else begin
                        w_nxt_state = c_ST_ACTIVE;
                        w_nxt_v     = r_v + 16'd1;
                    end
                end else begin
                    w_nxt_h = r_h + 16'd1;
                end
            end
            c_ST_VBLANK: begin
                if (r_h == c_LINE_LAST) begin
                    w_nxt_h = 16'd0;
                    if (r_v == c_VB_LAST) begin
                        w_nxt_v     = 16'd0;
                        w_nxt_state = i_enable ? c_ST_SYNC : c_ST_IDLE;
                    end else begin
                        w_nxt_v = r_v + 16'd1;
                    end
                end else begin
                    w_nxt_h = r_h + 16'd1;
                end
            end
            default: w_nxt_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_pix = {i_vramReadData[1], i_vramReadData[4], i_vramReadData[7]};
`ifdef TEST_PATTERN_EN
        if (i_testPattern) begin
            w_pix = w_nxt_h[7:5] ^ {w_nxt_v[3], 2'b00};
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= c_ST_IDLE;
            r_div        <= 8'd0;
            r_dclk       <= 1'b0;
            r_cls        <= 1'b0;
            r_sps        <= 1'b0;
            r_pix        <= 3'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_h          <= 16'd0;
            r_v          <= 16'd0;
            r_addr       <= 15'd0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                r_div  <= 8'd0;
                r_dclk <= 1'b0;
                if (i_enable) begin
                    // Entering SYNC is itself a DCLK rising edge.
                    r_state <= c_ST_SYNC;
                    r_dclk  <= 1'b1;
                    r_sps   <= 1'b1;
                    r_busy  <= 1'b1;
                    r_h     <= 16'd0;
                    r_v     <= 16'd0;
                end
            end else begin
                r_div <= (r_div == c_DIV_LAST) ? 8'd0 : r_div + 8'd1;
                if (w_fall) begin
                    r_dclk <= 1'b0;
                    // Prefetch the next pixel; the frame is linear so the line wrap is free.
                    if (r_state == c_ST_ACTIVE) begin
                        r_addr <= (r_addr == c_ADDR_LAST) ? 15'd0 : r_addr + 15'd1;
                    end
                end
                if (w_rise) begin
                    r_dclk  <= 1'b1;
                    r_state <= w_nxt_state;
                    r_h     <= w_nxt_h;
                    r_v     <= w_nxt_v;
                    r_sps   <= (w_nxt_state == c_ST_SYNC);
                    r_cls   <= (w_nxt_state == c_ST_ACTIVE);
                    r_pix   <= (w_nxt_state == c_ST_ACTIVE) ? w_pix : 3'd0;
                    if (r_state == c_ST_VBLANK && w_nxt_state != c_ST_VBLANK) begin
                        r_frame_done <= 1'b1;
                        if (w_nxt_state == c_ST_IDLE) begin
                            r_busy <= 1'b0;
                            r_dclk <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign o_vramReadAddr = r_addr;
    assign o_gbcDCLK      = r_dclk;
    assign o_gbcCLS       = r_cls;
    assign o_gbcSPS       = r_sps;
    assign o_gbcPixelData = r_pix;
    assign o_busy         = r_busy;
    assign o_frameDone    = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_gbc_display_emitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gbc_display_emitter
// Brief    : Bench for gbc_display_emitter with a frame-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gbc_display_emitter;

    localparam int D     = 2;
    localparam int H     = 160;
    localparam int V     = 4;
    localparam int HB    = 16;
    localparam int VB    = 2;
    localparam int LINE  = H + HB;
    localparam int FRAME = (1 + (V + VB) * LINE) * 2 * D;
    localparam int TOTAL = H * V;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic [7:0]  vram_q  = 8'd0;
    logic [14:0] o_vramReadAddr;
    logic        o_gbcDCLK, o_gbcCLS, o_gbcSPS, o_busy, o_frameDone;
    logic [2:0]  o_gbcPixelData;
`ifdef TEST_PATTERN_EN
    logic        tp = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mode_ff = 1'b0;

    always #5 i_clk = ~i_clk;

    gbc_display_emitter #(
        .CLK_DIV(D), .H_PIXELS(H), .V_PIXELS(V), .H_BLANK(HB), .V_BLANK(VB)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_enable       (i_enable),
`ifdef TEST_PATTERN_EN
        .i_testPattern  (tp),
`endif
        .i_vramReadData (vram_q),
        .o_vramReadAddr (o_vramReadAddr),
        .o_gbcDCLK      (o_gbcDCLK),
        .o_gbcCLS       (o_gbcCLS),
        .o_gbcSPS       (o_gbcSPS),
        .o_gbcPixelData (o_gbcPixelData),
        .o_busy         (o_busy),
        .o_frameDone    (o_frameDone)
    );

    function automatic logic [7:0] vram_fn(input int a);
        return mode_ff ? 8'hFF : a[7:0];
    endfunction

    function automatic logic [2:0] dec(input logic [7:0] d);
        return {d[1], d[4], d[7]};
    endfunction

    always @(posedge i_clk) vram_q <= vram_fn(int'(o_vramReadAddr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs as seen by the DUT at the last rising clock edge.
    bit en_s = 1'b0;
    bit rst_s = 1'b0;
    always @(posedge i_clk) begin
        en_s  = i_enable;
        rst_s = i_rst_n;
    end

    // Reference: position within the frame timeline, counted in clocks from SYNC.
    bit          m_run = 1'b0;
    bit          m_fd  = 1'b0;
    int          m_k   = 0;
    int          p, ph, q, line, col, done;
    logic        e_dclk, e_cls, e_sps;
    logic [2:0]  e_pix;
    logic [14:0] e_addr;

    // Receiver / statistics
    bit          prev_dclk = 1'b0;
    bit          prev_sps  = 1'b0;
    logic [2:0]  cap_mem [TOTAL];
    int cap_cnt, run_len, lines_seen, bad_lines, sps_clks, fd_cnt;
    int sps_first_cyc, fd_last_cyc, fd_prev_cyc;

    always @(negedge i_clk) begin
        cyc++;
        if (!i_rst_n || !rst_s) begin
            m_run = 1'b0; m_k = 0; m_fd = 1'b0;
        end else if (m_run) begin
            m_k++;
            if (m_k == FRAME) begin
                m_fd = 1'b1;
                if (en_s) m_k = 0;
                else      m_run = 1'b0;
            end else begin
                m_fd = 1'b0;
            end
        end else begin
            m_fd = 1'b0;
            if (en_s) begin
                m_run = 1'b1; m_k = 0;
            end
        end

        e_dclk = 1'b0; e_cls = 1'b0; e_sps = 1'b0; e_pix = 3'd0; e_addr = 15'd0;
        if (m_run) begin
            p  = m_k / (2 * D);
            ph = m_k % (2 * D);
            e_dclk = (ph < D);
            if (p == 0) begin
                e_sps = 1'b1;
            end else begin
                q = p - 1; line = q / LINE; col = q % LINE;
                if (line < V) begin
                    done = line * H + ((col < H) ? col : H);
                    if (col < H) begin
                        e_cls = 1'b1;
                        e_pix = dec(vram_fn(line * H + col));
                        if (ph >= D) done++;
                    end
                end else begin
                    done = TOTAL;
                end
                e_addr = 15'(done % TOTAL);
            end
        end
        chk("outputs{busy,done,dclk,cls,sps,pix,addr}",
            {9'd0, o_busy, o_frameDone, o_gbcDCLK, o_gbcCLS, o_gbcSPS, o_gbcPixelData, o_vramReadAddr},
            {9'd0, m_run, m_fd, e_dclk, e_cls, e_sps, e_pix, e_addr});

        if (o_gbcSPS) begin
            sps_clks++;
            if (!prev_sps && sps_first_cyc < 0) sps_first_cyc = cyc;
        end
        if (o_frameDone) begin
            fd_cnt++;
            fd_prev_cyc = fd_last_cyc;
            fd_last_cyc = cyc;
        end
        if (prev_dclk && !o_gbcDCLK) begin
            if (o_gbcCLS) begin
                if (cap_cnt < TOTAL) cap_mem[cap_cnt] = o_gbcPixelData;
                cap_cnt++;
                run_len++;
            end else if (run_len > 0) begin
                lines_seen++;
                if (run_len != H) bad_lines++;
                run_len = 0;
            end
        end
        prev_dclk = i_rst_n ? o_gbcDCLK : 1'b0;
        prev_sps  = o_gbcSPS;
    end

    task automatic clear_stats();
        cap_cnt = 0; run_len = 0; lines_seen = 0; bad_lines = 0; sps_clks = 0; fd_cnt = 0;
        sps_first_cyc = -1; fd_last_cyc = 0; fd_prev_cyc = 0;
        for (int i = 0; i < TOTAL; i++) cap_mem[i] = 3'd0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic wait_done(input int max_cycles);
        int start;
        bit ok;
        start = fd_cnt;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge i_clk);
            if (fd_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        #2;
        chk("frame_done_within_budget", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int errs;
        clear_stats();
        step(3);
        chk("reset_outputs", {o_busy, o_frameDone, o_gbcDCLK, o_gbcCLS, o_gbcSPS, o_gbcPixelData, o_vramReadAddr}, 0);
        i_rst_n = 1'b1;
        step(5);

        // Abort mid-ACTIVE with an asynchronous reset
        i_enable = 1'b1; step(1); i_enable = 1'b0;
        step(100);
        chk("mid_active_cls_busy", {o_gbcCLS, o_busy}, 2'b11);
        i_rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {o_busy, o_frameDone, o_gbcDCLK, o_gbcCLS, o_gbcSPS, o_gbcPixelData, o_vramReadAddr}, 0);
        step(3);
        i_rst_n = 1'b1;
        step(20);
        chk("idle_after_release_dclk_busy", {o_gbcDCLK, o_busy}, 2'b00);

        // One full frame from a single-clock enable pulse, VRAM = addr[7:0]
        clear_stats();
        i_enable = 1'b1; step(1); i_enable = 1'b0;
        wait_done(FRAME + 100);
        step(5);
        chk("sps_high_clocks", sps_clks, 4);
        chk("frame_length_clocks", fd_last_cyc - sps_first_cyc, 4228);
        chk("active_lines", lines_seen, 4);
        chk("lines_not_160_pixels", bad_lines, 0);
        chk("cls_falling_edges", cap_cnt, 640);
        chk("pixel_v1_h3", cap_mem[163], 3'b101);
        chk("pixel_v0_h146", cap_mem[146], 3'b111);
        chk("pixel_v2_h0", cap_mem[320], 3'b000);
        errs = 0;
        for (int h = 0; h < H; h++) begin
            if (cap_mem[H + h] !== dec(8'((H + h) & 255))) errs++;
        end
        chk("line1_decode_errors", errs, 0);
        chk("frame_done_pulses", fd_cnt, 1);
        chk("busy_after_frame", {31'd0, o_busy}, 0);

        // Loop-back with 0xFF everywhere
        mode_ff = 1'b1;
        step(2);
        clear_stats();
        i_enable = 1'b1; step(1); i_enable = 1'b0;
        wait_done(FRAME + 100);
        step(5);
        chk("ff_captured_count", cap_cnt, 640);
        errs = 0;
        for (int i = 0; i < TOTAL; i++) if (cap_mem[i] !== 3'b111) errs++;
        chk("ff_capture_errors", errs, 0);
        mode_ff = 1'b0;
        step(2);

        // Back-to-back frames, then drop enable mid-frame
        clear_stats();
        i_enable = 1'b1;
        wait_done(FRAME + 100);
        wait_done(FRAME + 100);
        chk("back_to_back_spacing", fd_last_cyc - fd_prev_cyc, 4228);
        step(1000);
        i_enable = 1'b0;
        wait_done(FRAME + 100);
        step(10);
        chk("b2b_frame_done_pulses", fd_cnt, 3);
        chk("b2b_busy_after_stop", {31'd0, o_busy}, 0);
        chk("b2b_sps_clocks", sps_clks, 12);
        chk("b2b_active_lines", lines_seen, 12);
        chk("b2b_bad_lines", bad_lines, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
